irq_ctl: RTL and testbench
==========================

Name: irq_ctl

Overview:
- Memory-mapped interrupt controller sitting directly upstream of mips_core.
- Collects N external interrupt sources and prioritises them.
- Drives the core's irq_i / irq_addr pair and consumes iack_o.
- Software programs and services it over the core's coprocessor port (cop_addr_o / cop_data_o / cop_mem_ctl_o in, cop_dout out).

Parameters:
- N_SRC, 8, number of interrupt sources (1..16).
- BASE_ADDR, 32'h0000_FF00, register window base; window is 32 bytes.
- VEC_SHIFT, 3, vector stride = 2^VEC_SHIFT bytes per source.
- WR_CODE, 4'd1, cop_mem_ctl value for a word write.
- RD_CODE, 4'd9, cop_mem_ctl value for a word read.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- irq_src_i  in  N_SRC  raw interrupt lines, asynchronous to clk
- cop_addr_i  in  32  register address from core
- cop_data_i  in  32  write data from core
- cop_mem_ctl_i  in  4  access type from core
- cop_dout_o  out  32  read data to core; 0 when not selected, because the core ORs it with memory data
- irq_o  out  1  interrupt request to core irq_i
- irq_addr_o  out  32  handler address to core irq_addr
- iack_i  in  1  acknowledge from core iack_o

Behaviour:
- Reset (rst=0, async) clears synchronizers, PEND, MASK, EDGE, VBASE, active index and FSM; irq_o=0, irq_addr_o=0, cop_dout_o=0.
- Input conditioning:
  - Each irq_src_i bit passes a 2-flop synchronizer, then a rising-edge detector (prev-flop).
  - Input-to-PEND latency is 3 clk.
- PEND[i]:
  - EDGE[i]=1: set on a synced rising edge; cleared by iack of that source or by W1C write.
  - EDGE[i]=0: equals the synced level every cycle; iack and W1C have no effect.
  - Set wins over any same-cycle clear.
- Register map (byte offsets from BASE_ADDR, word access only):
  - 0x00 PEND: read; write-1-to-clear.
  - 0x04 MASK: RW; 1 = enabled.
  - 0x08 EDGE: RW; 1 = edge mode.
  - 0x0C VBASE: RW, 32 bits.
  - 0x10 EOI: write-only; any data.
  - 0x14 STAT: read; {busy, state[1:0], idx[3:0]} in bits [6:0].
- Register access:
  - Writes occur when cop_mem_ctl_i==WR_CODE and the address is in the window; they take effect next edge.
  - Reads are combinational when cop_mem_ctl_i==RD_CODE and the address is in the window; otherwise cop_dout_o=0.
  - Unused bits and unmapped offsets read 0.
- Priority: lowest index among (PEND & MASK) wins.
- FSM IDLE:
  - If (PEND & MASK)!=0: latch winner into idx, drive irq_addr_o = VBASE + (idx << VEC_SHIFT), set irq_o=1, go to REQ.
  - Request latency is 1 clk after PEND sets.
- FSM REQ:
  - irq_o and irq_addr_o are held stable; a later higher-priority source does not re-arbitrate.
  - If iack_i=1: clear PEND[idx] (edge mode only), irq_o=0 next cycle, go to SERVICE.
  - If MASK[idx] or PEND[idx] drops before iack: irq_o=0, go to IDLE, re-arbitrate next cycle.
- FSM SERVICE:
  - irq_o=0; no new requests (no nesting).
  - EOI write: go to IDLE, arbitrate next cycle.
  - iack_i in SERVICE or IDLE is ignored.
- irq_addr_o holds its last value when irq_o=0.
- VBASE writes in REQ do not change irq_addr_o until the next arbitration.
- EOI written in IDLE or REQ is ignored.
- An iack and an EOI in the same cycle in REQ: the iack is processed, and the EOI is ignored.

Test Plan:
- Reset/readback: after rst release, MASK=0xFF, EDGE=0x01, VBASE=0x8000_0100 written → reads return the same values; PEND=0; irq_o=0; cop_dout_o=0 when cop_mem_ctl_i=0.
- Edge request: pulse irq_src_i[0] for 1 clk → PEND[0]=1 after 3 clk, irq_o=1 next clk, irq_addr_o=0x8000_0100; iack_i=1 → PEND[0]=0, irq_o=0, STAT state=SERVICE; EOI → IDLE, with no further request.
- Priority/freeze: sources 5 and 3 level-high, then 1 edge while in REQ on 3 → irq_addr_o=VBASE+0x18 stays until iack; after EOI, the next request is source 1 (VBASE+0x08).
- Level hold: source 2 level, held high through EOI → a new request follows 1 clk after EOI; deassert before iack → irq_o drops, return to IDLE.
- Mask drop: in REQ on source 4, write MASK bit 4=0 → irq_o=0 next clk, state IDLE.
- Simultaneous: an edge on source 0 in the same cycle as iack for source 0 → PEND[0] stays 1; W1C with a same-cycle edge → PEND stays 1; rst asserted in SERVICE → all state cleared immediately.

Source files
------------

// File: rtl/irq_ctl.sv
// irq_ctl: prioritised N-source interrupt controller in front of mips_core.
// Drives irq_o/irq_addr_o, consumes iack_i, programmed over the coprocessor port.
module irq_ctl #(
    parameter int unsigned N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
    parameter int unsigned VEC_SHIFT = 3,
    parameter logic [3:0]  WR_CODE   = 4'd1,
    parameter logic [3:0]  RD_CODE   = 4'd9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic [31:0]      cop_addr_i,
    input  logic [31:0]      cop_data_i,
    input  logic [3:0]       cop_mem_ctl_i,
    output logic [31:0]      cop_dout_o,
    output logic             irq_o,
    output logic [31:0]      irq_addr_o,
    input  logic             iack_i
);
    typedef logic [N_SRC-1:0] src_t;
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    localparam logic [2:0] OFF_PEND  = 3'd0;
    localparam logic [2:0] OFF_MASK  = 3'd1;
    localparam logic [2:0] OFF_EDGE  = 3'd2;
    localparam logic [2:0] OFF_VBASE = 3'd3;
    localparam logic [2:0] OFF_EOI   = 3'd4;
    localparam logic [2:0] OFF_STAT  = 3'd5;

    src_t        r_sync1, r_sync2, r_prev;
    src_t        r_pend, r_mask, r_edge;
    logic [31:0] r_vbase, r_irq_addr;
    logic        r_irq;
    logic [3:0]  r_idx;
    state_t      r_state;

    logic        w_in_win, w_wr, w_rd, w_eoi, w_req_live, w_any;
    logic [2:0]  w_off;
    src_t        w_rise, w_pm, w_idx_oh, w_clr, w_pend_nxt;
    logic [3:0]  w_win, w_idx_nxt;
    logic [31:0] w_addr_nxt;
    logic        w_irq_nxt;
    state_t      w_state_nxt;

    // Misaligned addresses are treated as outside the window (word access only).
    assign w_in_win = (cop_addr_i[31:5] == BASE_ADDR[31:5]) && (cop_addr_i[1:0] == 2'b00);
    assign w_off    = cop_addr_i[4:2];
    assign w_wr     = w_in_win && (cop_mem_ctl_i == WR_CODE);
    assign w_rd     = w_in_win && (cop_mem_ctl_i == RD_CODE);
    assign w_eoi    = w_wr && (w_off == OFF_EOI);

    assign w_rise   = r_sync2 & ~r_prev;
    assign w_pm     = r_pend & r_mask;
    assign w_any    = |w_pm;
    assign w_idx_oh = src_t'(1) << r_idx;
    assign w_req_live = |(w_pm & w_idx_oh);

    // Clears only touch edge-mode bits; a same-cycle rising edge overrides them.
    assign w_clr = ((r_state == S_REQ && iack_i) ? w_idx_oh : '0)
                 | ((w_wr && w_off == OFF_PEND) ? cop_data_i[N_SRC-1:0] : '0);
    assign w_pend_nxt = (r_edge & ((r_pend & ~w_clr) | w_rise)) | (~r_edge & r_sync2);

    always_comb begin
        w_win = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (w_pm[i-1]) w_win = 4'(i-1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_irq_nxt   = r_irq;
        w_idx_nxt   = r_idx;
        w_addr_nxt  = r_irq_addr;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_idx_nxt   = w_win;
                    w_addr_nxt  = r_vbase + (32'(w_win) << VEC_SHIFT);
                    w_irq_nxt   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (iack_i) begin
                    w_irq_nxt   = 1'b0;
                    w_state_nxt = S_SERVICE;
                end else if (!w_req_live) begin
                    w_irq_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_SERVICE: begin
                w_irq_nxt = 1'b0;
                if (w_eoi) w_state_nxt = S_IDLE;
            end
            default: begin
                w_irq_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_irq      <= 1'b0;
            r_idx      <= '0;
            r_irq_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_irq      <= w_irq_nxt;
            r_idx      <= w_idx_nxt;
            r_irq_addr <= w_addr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_edge  <= '0;
            r_vbase <= '0;
        end else begin
            r_sync1 <= irq_src_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pend  <= w_pend_nxt;
            if (w_wr) begin
                case (w_off)
                    OFF_MASK:  r_mask  <= cop_data_i[N_SRC-1:0];
                    OFF_EDGE:  r_edge  <= cop_data_i[N_SRC-1:0];
                    OFF_VBASE: r_vbase <= cop_data_i;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cop_dout_o = '0;
        if (w_rd) begin
            case (w_off)
                OFF_PEND:  cop_dout_o[N_SRC-1:0] = r_pend;
                OFF_MASK:  cop_dout_o[N_SRC-1:0] = r_mask;
                OFF_EDGE:  cop_dout_o[N_SRC-1:0] = r_edge;
                OFF_VBASE: cop_dout_o            = r_vbase;
                OFF_STAT:  cop_dout_o[6:0]       = {r_state != S_IDLE, r_state, r_idx};
                default: ;
            endcase
        end
    end

    assign irq_o      = r_irq;
    assign irq_addr_o = r_irq_addr;
endmodule

// File: tb/tb_irq_ctl.sv
// Scoreboard bench for irq_ctl: stimulus pushes per-cycle expectations from a
// behavioural model; an independent monitor pops and compares them.
module tb_irq_ctl;
    localparam int unsigned N    = 8;
    localparam logic [31:0] BASE = 32'h0000_FF00;
    localparam int unsigned VS   = 3;
    localparam logic [3:0]  WR   = 4'd1;
    localparam logic [3:0]  RD   = 4'd9;

    logic        clk = 1'b0;
    logic        rst;
    logic [N-1:0] irq_src_i;
    logic [31:0] cop_addr_i, cop_data_i, cop_dout_o, irq_addr_o;
    logic [3:0]  cop_mem_ctl_i;
    logic        irq_o, iack_i;

    always #5 clk = ~clk;

    irq_ctl #(
        .N_SRC(N), .BASE_ADDR(BASE), .VEC_SHIFT(VS), .WR_CODE(WR), .RD_CODE(RD)
    ) dut (
        .clk(clk), .rst(rst), .irq_src_i(irq_src_i),
        .cop_addr_i(cop_addr_i), .cop_data_i(cop_data_i), .cop_mem_ctl_i(cop_mem_ctl_i),
        .cop_dout_o(cop_dout_o), .irq_o(irq_o), .irq_addr_o(irq_addr_o), .iack_i(iack_i)
    );

    typedef struct {
        logic        irq;
        logic [31:0] addr;
        logic [31:0] dout;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    // Stimulus for the coming cycle
    logic        g_rst = 1'b0;
    logic [N-1:0] g_src = '0;
    logic [31:0] g_addr = '0, g_data = '0;
    logic [3:0]  g_ctl = '0;
    logic        g_iack = 1'b0;

    // Reference model: STAT state field is IDLE=0, REQ=1, SERVICE=2
    typedef enum int {M_IDLE = 0, M_REQ = 1, M_SVC = 2} mode_t;
    mode_t       m_mode;
    logic [N-1:0] m_pend, m_mask, m_edge;
    logic [N-1:0] h1, h2, h3;  // raw inputs seen 1, 2 and 3 edges ago
    logic [31:0] m_vbase, m_addr;
    logic        m_irq;
    int          m_idx;

    function void m_reset();
        m_mode = M_IDLE; m_pend = '0; m_mask = '0; m_edge = '0;
        h1 = '0; h2 = '0; h3 = '0;
        m_vbase = '0; m_addr = '0; m_irq = 1'b0; m_idx = 0;
    endfunction

    function bit in_win(logic [31:0] a);
        return (a[31:5] == BASE[31:5]) && (a[1:0] == 2'b00);
    endfunction

    function logic [31:0] m_read();
        int v;
        if (g_ctl != RD || !in_win(g_addr)) return 32'h0;
        case (g_addr[4:2])
            3'd0: return 32'(m_pend);
            3'd1: return 32'(m_mask);
            3'd2: return 32'(m_edge);
            3'd3: return m_vbase;
            3'd5: begin
                v = (m_mode != M_IDLE ? 64 : 0) + int'(m_mode) * 16 + m_idx;
                return 32'(v);
            end
            default: return 32'h0;
        endcase
    endfunction

    function void m_step();
        logic [N-1:0] pm, rise, clr, nxt;
        bit wr;
        pm   = m_pend & m_mask;
        rise = h2 & ~h3;
        clr  = '0;
        wr   = (g_ctl == WR) && in_win(g_addr);
        if (wr && g_addr[4:2] == 3'd0) clr = g_data[N-1:0];
        case (m_mode)
            M_IDLE: if (pm != 0) begin
                for (int i = 0; i < N; i++) if (pm[i]) begin m_idx = i; break; end
                m_addr = m_vbase + 32'(m_idx) * (32'd1 << VS);
                m_irq  = 1'b1;
                m_mode = M_REQ;
            end
            M_REQ: if (g_iack) begin
                clr[m_idx] = 1'b1;
                m_irq  = 1'b0;
                m_mode = M_SVC;
            end else if (!(m_mask[m_idx] && m_pend[m_idx])) begin
                m_irq  = 1'b0;
                m_mode = M_IDLE;
            end
            default: if (wr && g_addr[4:2] == 3'd4) m_mode = M_IDLE;
        endcase
        for (int i = 0; i < N; i++)
            nxt[i] = m_edge[i] ? (rise[i] | (m_pend[i] & ~clr[i])) : h2[i];
        if (wr) begin
            case (g_addr[4:2])
                3'd1: m_mask  = g_data[N-1:0];
                3'd2: m_edge  = g_data[N-1:0];
                3'd3: m_vbase = g_data;
                default: ;
            endcase
        end
        m_pend = nxt;
        h3 = h2; h2 = h1; h1 = g_src;
    endfunction

    function void chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        rst = g_rst; irq_src_i = g_src; cop_addr_i = g_addr;
        cop_data_i = g_data; cop_mem_ctl_i = g_ctl; iack_i = g_iack;
        if (!g_rst) m_reset();
        e.irq = m_irq; e.addr = m_addr; e.dout = m_read();
        sbq.push_back(e);
        if (g_rst) m_step();
    endtask

    task automatic op(logic [3:0] c, logic [31:0] a, logic [31:0] d);
        g_ctl = c; g_addr = a; g_data = d;
        tick();
        g_ctl = '0; g_addr = '0; g_data = '0;
    endtask

    task automatic wr(logic [4:0] off, logic [31:0] d); op(WR, BASE + 32'(off), d); endtask
    task automatic rd(logic [4:0] off); op(RD, BASE + 32'(off), 32'h0); endtask
    task automatic idle(int n); repeat (n) tick(); endtask
    task automatic ack(); g_iack = 1'b1; tick(); g_iack = 1'b0; endtask
    task automatic pulse(int s); g_src[s] = 1'b1; tick(); g_src[s] = 1'b0; endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("irq_o", 32'(irq_o), 32'(e.irq));
                chk("irq_addr_o", irq_addr_o, e.addr);
                chk("cop_dout_o", cop_dout_o, e.dout);
            end
        end
    end

    initial begin : stim
        int r;
        m_reset();
        g_rst = 1'b0; idle(3);
        g_rst = 1'b1; idle(2);
        // Reset / readback
        rd(5'h00); rd(5'h14);
        wr(5'h04, 32'hFF); wr(5'h08, 32'h01); wr(5'h0C, 32'h8000_0100);
        rd(5'h04); rd(5'h08); rd(5'h0C); rd(5'h00); rd(5'h10); rd(5'h18); idle(1);
        // Edge request on source 0, service, EOI
        pulse(0); idle(5); rd(5'h14);
        ack(); rd(5'h00); rd(5'h14);
        wr(5'h10, 32'h0); idle(4); rd(5'h14);
        // Priority and freeze: 5,3 level, then 1 edge during REQ on 3
        wr(5'h08, 32'h03);
        g_src = 8'h28; idle(5);
        pulse(1); idle(4);
        wr(5'h0C, 32'h8000_0200); idle(2);
        ack(); wr(5'h10, 32'h0); idle(3);
        ack(); wr(5'h10, 32'h0); idle(3);
        ack(); g_src = 8'h00; wr(5'h10, 32'h0); idle(5);
        // Level hold through EOI, then drop before iack
        g_src = 8'h04; idle(5); ack(); idle(2);
        wr(5'h10, 32'h0); idle(3);
        g_src = 8'h00; idle(5); rd(5'h14);
        // Mask drop while in REQ
        g_src = 8'h10; idle(5);
        wr(5'h04, 32'hEF); idle(3); rd(5'h14);
        g_src = 8'h00; wr(5'h04, 32'hFF); idle(4);
        // Edge coinciding with iack, and with W1C
        pulse(0); idle(5);
        pulse(0); tick(); ack(); rd(5'h00); rd(5'h14);
        pulse(0); tick(); wr(5'h00, 32'h01); rd(5'h00);
        // Reset while in SERVICE
        g_rst = 1'b0; g_ctl = RD; g_addr = BASE + 32'h14; tick();
        g_ctl = '0; g_addr = '0; tick();
        g_rst = 1'b1; rd(5'h00); rd(5'h04); rd(5'h0C); rd(5'h14);
        // Randomised traffic
        wr(5'h04, $urandom); wr(5'h08, $urandom); wr(5'h0C, $urandom);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) g_src = g_src ^ (8'(1) << $urandom_range(0, N - 1));
            g_iack = m_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            g_rst  = ($urandom_range(0, 599) != 0);
            r = int'($urandom_range(0, 15));
            g_ctl = '0; g_addr = '0; g_data = '0;
            case (r)
                0: begin g_ctl = WR; g_addr = BASE; g_data = $urandom; end
                1: begin g_ctl = WR; g_addr = BASE + 32'h04; g_data = $urandom | $urandom; end
                2: begin g_ctl = WR; g_addr = BASE + 32'h08; g_data = $urandom; end
                3: begin g_ctl = WR; g_addr = BASE + 32'h0C; g_data = $urandom; end
                4, 5: begin g_ctl = WR; g_addr = BASE + 32'h10; g_data = $urandom; end
                6, 7, 8: begin g_ctl = RD; g_addr = BASE + 32'($urandom_range(0, 7) * 4); end
                9: begin g_ctl = RD; g_addr = BASE + 32'($urandom_range(8, 64) * 4); end
                10: begin g_ctl = WR; g_addr = BASE + 32'($urandom_range(8, 64) * 4); g_data = $urandom; end
                11: begin g_ctl = 4'($urandom_range(2, 8)); g_addr = BASE + 32'($urandom_range(0, 4) * 4); g_data = $urandom; end
                default: ;
            endcase
            tick();
            if (!g_rst) begin
                g_rst = 1'b1; g_ctl = WR; g_addr = BASE + 32'h04; g_data = 32'hFF; tick();
            end
        end
        g_ctl = '0; g_addr = '0; g_data = '0; g_iack = 1'b0; g_rst = 1'b1;
        idle(2);
        @(negedge clk);
        #4;
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
